// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide sequencer for MULT/DIV.
// Radix-2 Booth multiply (32 cycles) and restoring divide on magnitudes (32 cycles + sign fix).
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {IDLE, MULT_RUN, DIV_RUN, DIV_FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] p_q, p_d, q_q, q_d, m_q, m_d;
  logic        q1_q, q1_d;
  logic [31:0] r_q, r_d, d_q, d_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [32:0] booth_sum;
  logic [32:0] r_sh;
  logic [31:0] abs_a, abs_b;

  always_comb begin
    abs_a = A[31] ? -A : A;
    abs_b = B[31] ? -B : B;
    // One extra sign bit so P-=M with M=-2^31 cannot overflow before the shift.
    booth_sum = {p_q[31], p_q};
    case ({q_q[0], q1_q})
      2'b01:   booth_sum = {p_q[31], p_q} + {m_q[31], m_q};
      2'b10:   booth_sum = {p_q[31], p_q} - {m_q[31], m_q};
      default: booth_sum = {p_q[31], p_q};
    endcase
    // Remainder stays below D after each step, so 32 stored bits suffice.
    r_sh = {r_q, q_q[31]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    r_d     = r_q;
    d_d     = d_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dz_d  = 1'b0;
          cnt_d = 6'd0;
          if (!op) begin
            p_d     = 32'd0;
            q_d     = A;
            q1_d    = 1'b0;
            m_d     = B;
            state_d = MULT_RUN;
          end else if (B != 32'd0) begin
            r_d     = 32'd0;
            q_d     = abs_a;
            d_d     = abs_b;
            sa_d    = A[31];
            sb_d    = B[31];
            state_d = DIV_RUN;
          end else begin
            // D=0 marks the divide-by-zero pass through DIV_FIX (|B| is never 0 otherwise).
            d_d     = 32'd0;
            state_d = DIV_FIX;
          end
        end
      end
      MULT_RUN: begin
        p_d   = booth_sum[32:1];
        q_d   = {booth_sum[0], q_q[31:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          hi_d    = p_d;
          lo_d    = q_d;
          state_d = DONE;
        end
      end
      DIV_RUN: begin
        if (r_sh >= {1'b0, d_q}) begin
          r_d = 32'(r_sh - {1'b0, d_q});
          q_d = {q_q[30:0], 1'b1};
        end else begin
          r_d = r_sh[31:0];
          q_d = {q_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        if (d_q == 32'd0) begin
          dz_d = 1'b1;
        end else begin
          lo_d = (sa_q ^ sb_q) ? -q_q : q_q;
          hi_d = sa_q ? -r_q : r_q;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      p_q     <= 32'd0;
      q_q     <= 32'd0;
      q1_q    <= 1'b0;
      m_q     <= 32'd0;
      r_q     <= 32'd0;
      d_q     <= 32'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      r_q     <= r_d;
      d_q     <= d_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign div_zero = dz_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes model results, a monitor checks each done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        busy, done, div_zero;
  logic [31:0] HI, LO;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .div_zero(div_zero), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] mhi = '0, mlo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", HI, e.hi);
        chk("lo", LO, e.lo);
        chk("div_zero", 32'(div_zero), 32'(e.dz));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drive one start; returns at the negedge after the accepting edge.
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint x, y;
    int     lat;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; op = $urandom_range(0, 1);
    x = longint'($signed(a));
    y = longint'($signed(b));
    e.dz = 1'b0;
    if (!o) begin
      longint prod;
      prod = x * y;
      mhi = prod[63:32]; mlo = prod[31:0];
      lat = 32;
    end else if (b == 32'd0) begin
      e.dz = 1'b1;
      lat = 1;
    end else begin
      longint qq, rr;
      qq = x / y; rr = x % y;
      mhi = rr[31:0]; mlo = qq[31:0];
      lat = 33;
    end
    e.hi = mhi; e.lo = mlo; e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    chk("busy_running", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    @(negedge clk);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic run(input logic o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b);
    wait_done();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b1;

    run(1'b0, 32'd7, 32'hFFFF_FFFD);
    run(1'b0, 32'h8000_0000, 32'h8000_0000);
    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(1'b1, 32'hFFFF_FFF9, 32'd2);
    run(1'b1, 32'd100, 32'd7);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    run(1'b1, 32'hDEAD_BEEF, 32'd0);
    repeat (4) @(negedge clk);
    chk("dz_sticky", 32'(div_zero), 32'd1);
    chk("hold_hi", HI, mhi);
    run(1'b1, 32'd9, 32'hFFFF_FFFE);
    chk("dz_cleared", 32'(div_zero), 32'd0);

    // Start pulsed mid-MULT must be ignored.
    issue(1'b0, 32'hFFFF_8001, 32'h0003_0007);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 1'b1; A = 32'd55; B = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'(longint'($urandom_range(0, 20)) - 10);
        default: ;
      endcase
      run(1'($urandom_range(0, 1)), a, b);
    end

    // Asynchronous reset mid-DIV.
    run(1'b0, 32'h0BAD_F00D, 32'h7);
    issue(1'b1, 32'h7FFF_FFFF, 32'd13);
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    chk("arst_dz", 32'(div_zero), 32'd0);
    sb.delete();
    mhi = '0; mlo = '0;
    @(negedge clk);
    reset = 1'b1;
    run(1'b0, 32'd3, 32'd4);
    chk("post_rst_lo", LO, 32'd12);
    chk("post_rst_hi", HI, 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
